vram_arbiter: RTL and testbench

Shares the single-port video RAM between the VGA scan-out fetcher and the KR580 CPU bus. Video fetches are timing-critical and always win their cycle. CPU writes are posted into a small FIFO and drained in free cycles. CPU reads wait for the FIFO to drain, then use a free cycle, so read-after-write ordering holds. Sits between the `vga` fetch port, the CPU bus decoder and the VRAM block.

---
 rtl/vram_arbiter_if.sv | 28 ++
 rtl/vram_arbiter.sv | 133 +++++++++++++
 tb/tb_vram_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: CPU-side bus between the KR580 bus decoder and the VRAM arbiter.
//   c_req    level request, held with c_we/c_addr/c_wdata stable until c_ready
//   c_we     1 = write, 0 = read
//   c_addr   VRAM byte address
//   c_wdata  write data
//   c_rdata  read data, valid while c_ready=1 after a read
//   c_ready  one-cycle completion pulse
// master = CPU side, slave = arbiter side.
interface vram_arbiter_if #(
    parameter int AW = 13
);
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [7:0]    c_wdata;
    logic [7:0]    c_rdata;
    logic          c_ready;

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_rdata, c_ready
    );

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_rdata, c_ready
    );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port VRAM between the VGA fetcher and the CPU.
// Video always owns its cycle; CPU writes are posted to a small FIFO and drained
// in free cycles; CPU reads wait for the FIFO to empty so read-after-write holds.
//
// Ports:
//   clock, reset      system clock, async active-high reset
//   v_req/v_addr      video fetch request and address (always served)
//   v_rdata/v_valid   video data, valid the cycle after v_req
//   cpu               CPU bus (vram_arbiter_if.slave)
//   c_stall_cnt       saturating count of cycles with c_req=1 and c_ready=0
//   pending           write FIFO non-empty
//   m_addr/m_we/m_wdata/m_rdata  synchronous RAM port (read data one cycle late)
//
// CPU FSM:
//   state | meaning
//   IDLE  | waiting for a CPU request
//   WACK  | write posted, c_ready pulse
//   RWAIT | read accepted, waiting for a free memory cycle
//   RDATA | read issued last cycle, capturing m_rdata
//   RACK  | read complete, c_ready pulse
module vram_arbiter #(
    parameter int AW    = 13,
    parameter int DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              v_req,
    input  logic [AW-1:0]     v_addr,
    output logic [7:0]        v_rdata,
    output logic              v_valid,
    vram_arbiter_if.slave     cpu,
    output logic [15:0]       c_stall_cnt,
    output logic              pending,
    output logic [AW-1:0]     m_addr,
    output logic              m_we,
    output logic [7:0]        m_wdata,
    input  logic [7:0]        m_rdata
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {IDLE, WACK, RWAIT, RDATA, RACK} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] fifo_addr [DEPTH];
    logic [7:0]    fifo_data [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          fifo_full, fifo_empty;
    logic          push, pop, issue;

    assign fifo_full  = (count == (PW+1)'(DEPTH));
    assign fifo_empty = (count == '0);
    assign pending    = !fifo_empty;
    assign v_rdata    = m_rdata;

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        pop       = 1'b0;
        issue     = 1'b0;
        m_addr    = v_addr;
        m_we      = 1'b0;
        m_wdata   = fifo_data[rd_ptr];

        // memory-cycle priority: video, then write drain, then read issue
        if (!v_req) begin
            if (!fifo_empty) begin
                pop    = 1'b1;
                m_addr = fifo_addr[rd_ptr];
                m_we   = !reset;
            end else if (state == RWAIT) begin
                issue  = 1'b1;
                m_addr = cpu.c_addr;
            end
        end

        case (state)
            IDLE: begin
                if (cpu.c_req) begin
                    if (cpu.c_we) begin
                        // fullness is judged on the current count, even if a pop happens this cycle
                        if (!fifo_full) begin
                            push      = 1'b1;
                            state_nxt = WACK;
                        end
                    end else begin
                        state_nxt = RWAIT;
                    end
                end
            end
            WACK:    state_nxt = IDLE;
            RWAIT:   if (issue) state_nxt = RDATA;
            RDATA:   state_nxt = RACK;
            RACK:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            v_valid     <= 1'b0;
            cpu.c_ready <= 1'b0;
            cpu.c_rdata <= 8'h00;
            c_stall_cnt <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            v_valid     <= v_req;
            cpu.c_ready <= (state_nxt == WACK) || (state_nxt == RACK);
            if (state == RDATA) cpu.c_rdata <= m_rdata;
            if (cpu.c_req && !cpu.c_ready && (c_stall_cnt != 16'hFFFF))
                c_stall_cnt <= c_stall_cnt + 1'b1;
        end
    end

    // storage needs no reset: entries are only read while count says they are valid
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr[wr_ptr] <= cpu.c_addr;
            fifo_data[wr_ptr] <= cpu.c_wdata;
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;
    localparam int AW    = 13;
    localparam int DEPTH = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          v_req;
    logic [AW-1:0] v_addr;
    logic [7:0]    v_rdata;
    logic          v_valid;
    logic [15:0]   c_stall_cnt;
    logic          pending;
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [7:0]    m_wdata;
    logic [7:0]    m_rdata;

    always #5 clock = ~clock;

    vram_arbiter_if #(.AW(AW)) bus();

    vram_arbiter #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .v_req       (v_req),
        .v_addr      (v_addr),
        .v_rdata     (v_rdata),
        .v_valid     (v_valid),
        .cpu         (bus),
        .c_stall_cnt (c_stall_cnt),
        .pending     (pending),
        .m_addr      (m_addr),
        .m_we        (m_we),
        .m_wdata     (m_wdata),
        .m_rdata     (m_rdata)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // bench RAM standing in for the VRAM block, and the reference memory image
    logic [7:0] ram    [8192];
    logic [7:0] refmem [8192];
    logic [7:0] rd_latch;

    // reference model: queue of posted writes plus the outstanding CPU job
    logic [12:0] q_addr [$];
    logic [7:0]  q_data [$];
    bit          busy, rd_wait, cap;
    logic [12:0] rd_addr;
    logic [7:0]  rd_val;
    bit          e_ready, e_vvalid;
    logic [7:0]  e_rdata, e_vdata;
    int          e_stall;

    // CPU stimulus
    bit          op_we_q   [$];
    logic [12:0] op_addr_q [$];
    logic [7:0]  op_data_q [$];
    bit          cur_active, cur_we;
    logic [12:0] cur_addr;
    logic [7:0]  cur_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic add_op(input bit we, input logic [12:0] a, input logic [7:0] d);
        op_we_q.push_back(we);
        op_addr_q.push_back(a);
        op_data_q.push_back(d);
    endtask

    task automatic model_reset();
        q_addr.delete();
        q_data.delete();
        busy = 0; rd_wait = 0; cap = 0;
        e_ready = 0; e_vvalid = 0; e_rdata = 8'h00; e_stall = 0;
    endtask

    task automatic compare(input bit rst, input bit vr, input logic [12:0] va);
        bit          exp_we;
        logic [12:0] exp_addr;
        exp_we   = !rst && !vr && (q_addr.size() > 0);
        exp_addr = vr ? va : (q_addr.size() > 0) ? q_addr[0] : rd_wait ? rd_addr : va;
        chk("m_we",    32'(m_we),    32'(exp_we));
        chk("m_addr",  32'(m_addr),  32'(exp_addr));
        if (exp_we) chk("m_wdata", 32'(m_wdata), 32'(q_data[0]));
        chk("c_ready", 32'(bus.c_ready), 32'(e_ready));
        chk("c_rdata", 32'(bus.c_rdata), 32'(e_rdata));
        chk("v_valid", 32'(v_valid), 32'(e_vvalid));
        if (e_vvalid) chk("v_rdata", 32'(v_rdata), 32'(e_vdata));
        chk("pending", 32'(pending), 32'(q_addr.size() > 0));
        chk("stall",   32'(c_stall_cnt), e_stall);
    endtask

    task automatic model_edge(input bit rst, input bit vr, input logic [12:0] va);
        bit done, issue, pop;
        int pre;
        if (rst) return;
        done  = e_ready;
        pre   = q_addr.size();
        pop   = !vr && (pre > 0);
        issue = rd_wait && !vr && (pre == 0);
        if (cur_active && !e_ready && e_stall < 65535) e_stall++;
        e_vvalid = vr;
        if (vr) e_vdata = refmem[va];
        if (pop) begin
            refmem[q_addr[0]] = q_data[0];
            void'(q_addr.pop_front());
            void'(q_data.pop_front());
        end
        e_ready = 0;
        if (cap) begin
            e_rdata = rd_val;
            e_ready = 1;
            cap     = 0;
        end
        if (issue) begin
            rd_val  = refmem[rd_addr];
            cap     = 1;
            rd_wait = 0;
        end
        if (!busy && cur_active) begin
            if (cur_we) begin
                if (pre < DEPTH) begin
                    q_addr.push_back(cur_addr);
                    q_data.push_back(cur_data);
                    e_ready = 1;
                    busy    = 1;
                end
            end else begin
                rd_wait = 1;
                rd_addr = cur_addr;
                busy    = 1;
            end
        end else if (done) begin
            busy = 0;
        end
        if (done) cur_active = 0;
    endtask

    task automatic step(input bit rst, input bit vr, input logic [12:0] va);
        @(negedge clock);
        m_rdata = rd_latch;
        if (rst) begin
            op_we_q.delete(); op_addr_q.delete(); op_data_q.delete();
            cur_active = 0;
        end else if (!cur_active && op_we_q.size() > 0) begin
            cur_we     = op_we_q.pop_front();
            cur_addr   = op_addr_q.pop_front();
            cur_data   = op_data_q.pop_front();
            cur_active = 1;
        end
        reset       = rst;
        v_req       = vr;
        v_addr      = va;
        bus.c_req   = cur_active;
        bus.c_we    = cur_we;
        bus.c_addr  = cur_addr;
        bus.c_wdata = cur_data;
        if (rst) model_reset();
        #1;
        compare(rst, vr, va);
        rd_latch = ram[m_addr];
        if (m_we) ram[m_addr] = m_wdata;
        model_edge(rst, vr, va);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 13'h0000);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) begin
            refmem[i] = 8'($urandom);
            ram[i]    = refmem[i];
        end
        rd_latch = 8'h00; m_rdata = 8'h00;
        cur_active = 0; cur_we = 0; cur_addr = '0; cur_data = '0;
        reset = 1'b1; v_req = 1'b0; v_addr = '0;
        bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
        model_reset();

        step(1'b1, 1'b0, 13'h0000);
        step(1'b1, 1'b0, 13'h0000);
        chk("rst_ready",   32'(bus.c_ready),   32'd0);
        chk("rst_rdata",   32'(bus.c_rdata),   32'd0);
        chk("rst_pending", 32'(pending),       32'd0);
        chk("rst_stall",   32'(c_stall_cnt),   32'd0);
        idle(2);

        // reset while the FIFO drain is writing
        add_op(1'b1, 13'h0300, 8'h11);
        add_op(1'b1, 13'h0301, 8'h22);
        for (int t = 1; t <= 8; t++) begin
            step(t == 6, t <= 4, 13'(13'h0040 + t));
            if (t == 5) chk("rs_drain_we", 32'(m_we), 32'd1);
            if (t == 6) begin
                chk("rs_we",      32'(m_we),        32'd0);
                chk("rs_ready",   32'(bus.c_ready), 32'd0);
                chk("rs_vvalid",  32'(v_valid),     32'd0);
                chk("rs_pending", 32'(pending),     32'd0);
                chk("rs_stall",   32'(c_stall_cnt), 32'd0);
                chk("rs_rdata",   32'(bus.c_rdata), 32'd0);
            end
            if (t == 7) begin
                chk("rs_post_pending", 32'(pending), 32'd0);
                chk("rs_post_we",      32'(m_we),    32'd0);
            end
        end

        // FIFO full under continuous video
        add_op(1'b1, 13'h0400, 8'hA1);
        add_op(1'b1, 13'h0401, 8'hA2);
        add_op(1'b1, 13'h0402, 8'hA3);
        for (int t = 1; t <= 11; t++) begin
            step(1'b0, t <= 7, 13'(13'h0080 + t));
            chk("ff_ready", 32'(bus.c_ready), 32'(t == 2 || t == 4 || t == 10));
        end
        chk("ff_stall", 32'(c_stall_cnt), 32'd7);
        idle(3);

        // video priority over a posted write
        add_op(1'b1, 13'h0100, 8'h5A);
        for (int t = 1; t <= 8; t++) begin
            step(1'b0, t <= 6, 13'(13'h0040 + t));
            chk("vp_ready", 32'(bus.c_ready), 32'(t == 2));
            chk("vp_we",    32'(m_we),        32'(t == 7));
            if (t == 7) begin
                chk("vp_addr",  32'(m_addr),  32'h0100);
                chk("vp_wdata", 32'(m_wdata), 32'h5A);
            end
        end
        idle(2);

        // read-after-write: the write drains before the read issues
        add_op(1'b1, 13'h0ABC, 8'h33);
        add_op(1'b0, 13'h0ABC, 8'h00);
        for (int t = 1; t <= 7; t++) begin
            step(1'b0, 1'b0, 13'h0000);
            chk("raw_ready", 32'(bus.c_ready), 32'(t == 2 || t == 6));
            if (t == 2) begin
                chk("raw_we",    32'(m_we),   32'd1);
                chk("raw_waddr", 32'(m_addr), 32'h0ABC);
            end
            if (t == 4) begin
                chk("raw_issue_we",   32'(m_we),   32'd0);
                chk("raw_issue_addr", 32'(m_addr), 32'h0ABC);
            end
            if (t == 6) chk("raw_rdata", 32'(bus.c_rdata), 32'h33);
        end
        idle(2);

        // read delayed by two video cycles
        add_op(1'b0, 13'h1F00, 8'h00);
        for (int t = 1; t <= 7; t++) begin
            step(1'b0, t == 2 || t == 3, 13'h0020);
            chk("rv_ready",  32'(bus.c_ready), 32'(t == 6));
            chk("rv_vvalid", 32'(v_valid),     32'(t == 3 || t == 4));
            if (t == 4) chk("rv_issue", 32'(m_addr), 32'h1F00);
        end
        idle(2);

        // reset while a read is capturing; a fresh read then completes normally
        add_op(1'b0, 13'h0555, 8'h00);
        for (int t = 1; t <= 9; t++) begin
            if (t == 5) add_op(1'b0, 13'h0556, 8'h00);
            step(t == 3, 1'b0, 13'h0000);
            chk("rr_ready", 32'(bus.c_ready), 32'(t == 8));
        end
        idle(2);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if (!cur_active && op_we_q.size() == 0 && $urandom_range(0, 2) == 0)
                add_op(1'($urandom_range(0, 1)), 13'(13'h0A00 + $urandom_range(0, 7)), 8'($urandom));
            step(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 99) < 40),
                 13'(13'h0A00 + $urandom_range(0, 15)));
        end
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
